// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU, and the EX/MEM pipeline register
// with stall/flush control and a count of instructions retired into EX/MEM.
module ex_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [2:0]       alu_op,
  input  logic             alu_src,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic [WIDTH-1:0] imm,
  input  logic [4:0]       rd_addr,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             reg_write,
  input  logic             mem_to_reg,
  input  logic [1:0]       fwd_a,
  input  logic [1:0]       fwd_b,
  input  logic [WIDTH-1:0] exmem_fwd_data,
  input  logic [WIDTH-1:0] memwb_fwd_data,
  output logic             exmem_valid,
  output logic [WIDTH-1:0] exmem_alu_result,
  output logic             exmem_zero,
  output logic [WIDTH-1:0] exmem_store_data,
  output logic [4:0]       exmem_rd,
  output logic             exmem_mem_read,
  output logic             exmem_mem_write,
  output logic             exmem_reg_write,
  output logic             exmem_mem_to_reg,
  output logic [31:0]      exec_count
);

  typedef enum logic [2:0] {
    AluAnd = 3'b000,
    AluOr  = 3'b001,
    AluAdd = 3'b010,
    AluSub = 3'b110,
    AluSlt = 3'b111
  } aluOp_e;

  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] fwdRt;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] aluResult;
  logic [31:0]      execCount;

  // 11 falls through to the ID/EX operand, same as 00
  function automatic logic [WIDTH-1:0] fwdMux(input logic [1:0] sel,
                                               input logic [WIDTH-1:0] idEx,
                                               input logic [WIDTH-1:0] exMem,
                                               input logic [WIDTH-1:0] memWb);
    case (sel)
      2'b10:   return exMem;
      2'b01:   return memWb;
      default: return idEx;
    endcase
  endfunction

  always_comb begin
    opA   = fwdMux(fwd_a, rs_data, exmem_fwd_data, memwb_fwd_data);
    fwdRt = fwdMux(fwd_b, rt_data, exmem_fwd_data, memwb_fwd_data);
    opB   = alu_src ? imm : fwdRt;
  end

  // Unassigned codes execute add
  always_comb begin
    aluResult = '0;
    case (alu_op)
      AluAnd:  aluResult = opA & opB;
      AluOr:   aluResult = opA | opB;
      AluSub:  aluResult = opA - opB;
      AluSlt:  aluResult = {{(WIDTH-1){1'b0}}, ($signed(opA) < $signed(opB))};
      default: aluResult = opA + opB;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exmem_valid      <= 1'b0;
      exmem_alu_result <= '0;
      exmem_zero       <= 1'b0;
      exmem_store_data <= '0;
      exmem_rd         <= '0;
      exmem_mem_read   <= 1'b0;
      exmem_mem_write  <= 1'b0;
      exmem_reg_write  <= 1'b0;
      exmem_mem_to_reg <= 1'b0;
      execCount        <= '0;
    end else if (flush) begin
      exmem_valid      <= 1'b0;
      exmem_alu_result <= '0;
      exmem_zero       <= 1'b0;
      exmem_store_data <= '0;
      exmem_rd         <= '0;
      exmem_mem_read   <= 1'b0;
      exmem_mem_write  <= 1'b0;
      exmem_reg_write  <= 1'b0;
      exmem_mem_to_reg <= 1'b0;
    end else if (!stall) begin
      // Bubbles still load data fields; only valid and controls are gated
      exmem_valid      <= id_valid;
      exmem_alu_result <= aluResult;
      exmem_zero       <= (aluResult == '0);
      exmem_store_data <= fwdRt;
      exmem_rd         <= rd_addr;
      exmem_mem_read   <= mem_read   & id_valid;
      exmem_mem_write  <= mem_write  & id_valid;
      exmem_reg_write  <= reg_write  & id_valid;
      exmem_mem_to_reg <= mem_to_reg & id_valid;
      if (id_valid) execCount <= execCount + 32'd1;
    end
  end

  assign exec_count = execCount;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed ALU/forwarding/stall/flush/counter
// cases plus randomized traffic, all checked against a behavioural model.
module tb_ex_stage;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst, stall, flush, id_valid, alu_src;
  logic [2:0]   alu_op;
  logic [W-1:0] rs_data, rt_data, imm, exmem_fwd_data, memwb_fwd_data;
  logic [4:0]   rd_addr;
  logic         mem_read, mem_write, reg_write, mem_to_reg;
  logic [1:0]   fwd_a, fwd_b;

  logic         exmem_valid, exmem_zero;
  logic [W-1:0] exmem_alu_result, exmem_store_data;
  logic [4:0]   exmem_rd;
  logic         exmem_mem_read, exmem_mem_write, exmem_reg_write, exmem_mem_to_reg;
  logic [31:0]  exec_count;

  int total = 0;
  int bad   = 0;

  // Model of the EX/MEM register contents
  logic         mValid, mZero, mMr, mMw, mRw, mM2r;
  logic [W-1:0] mRes, mStore;
  logic [4:0]   mRd;
  logic [31:0]  mCnt;

  always #5 clk = ~clk;

  ex_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .alu_op(alu_op), .alu_src(alu_src), .rs_data(rs_data), .rt_data(rt_data),
    .imm(imm), .rd_addr(rd_addr), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .exmem_fwd_data(exmem_fwd_data), .memwb_fwd_data(memwb_fwd_data),
    .exmem_valid(exmem_valid), .exmem_alu_result(exmem_alu_result),
    .exmem_zero(exmem_zero), .exmem_store_data(exmem_store_data),
    .exmem_rd(exmem_rd), .exmem_mem_read(exmem_mem_read),
    .exmem_mem_write(exmem_mem_write), .exmem_reg_write(exmem_reg_write),
    .exmem_mem_to_reg(exmem_mem_to_reg), .exec_count(exec_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    chk({tag, ".valid"}, {31'b0, exmem_valid}, {31'b0, mValid});
    chk({tag, ".result"}, exmem_alu_result, mRes);
    chk({tag, ".zero"}, {31'b0, exmem_zero}, {31'b0, mZero});
    chk({tag, ".store"}, exmem_store_data, mStore);
    chk({tag, ".rd"}, {27'b0, exmem_rd}, {27'b0, mRd});
    chk({tag, ".ctl"}, {28'b0, exmem_mem_read, exmem_mem_write, exmem_reg_write, exmem_mem_to_reg},
        {28'b0, mMr, mMw, mRw, mM2r});
    chk({tag, ".count"}, exec_count, mCnt);
  endtask

  task automatic modelClear(input logic clrCnt);
    mValid = 0; mZero = 0; mMr = 0; mMw = 0; mRw = 0; mM2r = 0;
    mRes = '0; mStore = '0; mRd = '0;
    if (clrCnt) mCnt = '0;
  endtask

  function automatic logic [W-1:0] pick(input logic [1:0] s, input logic [W-1:0] own);
    if (s == 2'b10) return exmem_fwd_data;
    if (s == 2'b01) return memwb_fwd_data;
    return own;
  endfunction

  // One clock: predict from current inputs, clock, then compare
  task automatic step(input string tag);
    logic [W-1:0] a, rt, b, r;
    a  = pick(fwd_a, rs_data);
    rt = pick(fwd_b, rt_data);
    b  = alu_src ? imm : rt;
    case (alu_op)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd6:    r = a - b;
      3'd7:    r = ($signed(a) < $signed(b)) ? 1 : 0;
      default: r = a + b;
    endcase
    @(posedge clk);
    #1;
    if (flush) modelClear(1'b0);
    else if (!stall) begin
      mValid = id_valid; mRes = r; mZero = (r == 0); mStore = rt; mRd = rd_addr;
      mMr = mem_read & id_valid; mMw = mem_write & id_valid;
      mRw = reg_write & id_valid; mM2r = mem_to_reg & id_valid;
      if (id_valid) mCnt = mCnt + 1;
    end
    checkAll(tag);
  endtask

  task automatic setOp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    alu_op = op; rs_data = a; rt_data = b; alu_src = 0; fwd_a = 0; fwd_b = 0;
  endtask

  initial begin
    rst = 0; stall = 0; flush = 0; id_valid = 1; alu_src = 0; alu_op = 3'd2;
    rs_data = '0; rt_data = '0; imm = '0; exmem_fwd_data = '0; memwb_fwd_data = '0;
    rd_addr = '0; mem_read = 0; mem_write = 0; reg_write = 1; mem_to_reg = 0;
    fwd_a = 0; fwd_b = 0;
    modelClear(1'b1);
    #12;
    checkAll("por");
    rst = 1;

    // ALU ops with A=0xC, B=0xA
    setOp(3'd0, 32'hC, 32'hA); step("and"); chk("and.val", exmem_alu_result, 32'h8);
    setOp(3'd1, 32'hC, 32'hA); step("or");  chk("or.val",  exmem_alu_result, 32'hE);
    setOp(3'd2, 32'hC, 32'hA); step("add"); chk("add.val", exmem_alu_result, 32'h16);
    setOp(3'd6, 32'hC, 32'hA); step("sub"); chk("sub.val", exmem_alu_result, 32'h2);
    setOp(3'd7, 32'hC, 32'hA); step("slt0"); chk("slt0.val", exmem_alu_result, 32'h0);
    setOp(3'd7, 32'hFFFFFFFF, 32'h1); step("slt1"); chk("slt1.val", exmem_alu_result, 32'h1);
    setOp(3'd6, 32'h5, 32'h5); step("subz"); chk("subz.zero", {31'b0, exmem_zero}, 32'h1);
    setOp(3'd4, 32'h3, 32'h4); step("op100"); chk("op100.val", exmem_alu_result, 32'h7);

    // Forwarding on operand A
    setOp(3'd2, 32'h1, 32'h0); alu_src = 1; imm = 32'h4;
    exmem_fwd_data = 32'h100; memwb_fwd_data = 32'h200;
    fwd_a = 2'b10; step("fwdEx");  chk("fwdEx.val", exmem_alu_result, 32'h104);
    fwd_a = 2'b01; step("fwdWb");  chk("fwdWb.val", exmem_alu_result, 32'h204);
    fwd_a = 2'b11; step("fwd11");  chk("fwd11.val", exmem_alu_result, 32'h5);

    // Store data path takes forwarded rt, ahead of the imm mux
    fwd_a = 2'b00; fwd_b = 2'b10; exmem_fwd_data = 32'hDEAD; mem_write = 1;
    step("store");
    chk("store.data", exmem_store_data, 32'hDEAD);
    chk("store.res", exmem_alu_result, 32'h5);
    mem_write = 0; fwd_b = 0;

    // Stall holds for three cycles while inputs change
    setOp(3'd2, 32'h10, 32'h20); reg_write = 1; rd_addr = 5'd7; step("cap");
    chk("cap.rd", {27'b0, exmem_rd}, 32'd7);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rs_data = $urandom; rt_data = $urandom; rd_addr = 5'($urandom); alu_op = 3'($urandom);
      step("stall");
      chk("stall.rd", {27'b0, exmem_rd}, 32'd7);
    end
    flush = 1; step("stflush");
    chk("stflush.valid", {31'b0, exmem_valid}, 32'h0);
    chk("stflush.rd", {27'b0, exmem_rd}, 32'h0);
    stall = 0; flush = 0;

    // Asynchronous reset mid-stall with nonzero outputs
    setOp(3'd2, 32'h1, 32'h1); rd_addr = 5'd3; step("pre");
    stall = 1; step("pre.st");
    #2 rst = 0; #1;
    modelClear(1'b1);
    checkAll("areset");
    #3 rst = 1; stall = 0;

    // Counter: 5 valid, 2 bubbles, 1 flush
    for (int i = 0; i < 5; i++) begin id_valid = 1; rs_data = $urandom; step("cntv"); end
    id_valid = 0;
    for (int i = 0; i < 2; i++) step("cntb");
    flush = 1; id_valid = 1; step("cntf"); flush = 0;
    chk("cnt5", exec_count, 32'd5);

    // Wrap: preload the counter to all ones
    force dut.execCount = 32'hFFFFFFFF;
    #1 release dut.execCount;
    mCnt = 32'hFFFFFFFF;
    id_valid = 1; step("wrap");
    chk("wrap.zero", exec_count, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      stall = ($urandom_range(0, 6) == 0);
      flush = ($urandom_range(0, 9) == 0);
      id_valid = ($urandom_range(0, 4) != 0);
      alu_op = 3'($urandom); alu_src = 1'($urandom);
      fwd_a = 2'($urandom); fwd_b = 2'($urandom);
      rs_data = $urandom; rt_data = ($urandom_range(0, 5) == 0) ? rs_data : $urandom;
      imm = $urandom; exmem_fwd_data = $urandom; memwb_fwd_data = $urandom;
      rd_addr = 5'($urandom);
      {mem_read, mem_write, reg_write, mem_to_reg} = 4'($urandom);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the MIPS pipeline, directly downstream of the ALU controller. Takes the 3-bit ALU operation code plus the ID/EX operands, applies forwarding, performs the ALU operation, and captures result and control into the EX/MEM pipeline register. Stall and flush support, plus a counter of instructions retired into EX/MEM.

## Interface
- WIDTH, 32, datapath width in bits.
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  hold EX/MEM register contents.
- flush  in  1  insert bubble into EX/MEM; priority over stall.
- id_valid  in  1  ID/EX slot holds a real instruction.
- alu_op  in  3  000 and, 001 or, 010 add, 110 sub, 111 slt.
- alu_src  in  1  0: operand B = forwarded rt; 1: operand B = imm.
- rs_data, rt_data  in  WIDTH  register-file operands.
- imm  in  WIDTH  sign-extended immediate.
- rd_addr  in  5  destination register, already selected upstream.
- mem_read, mem_write, reg_write, mem_to_reg  in  1 each  control bits from ID/EX.
- fwd_a, fwd_b  in  2  forwarding selects: 00 ID/EX operand, 10 exmem_fwd_data, 01 memwb_fwd_data, 11 same as 00.
- exmem_fwd_data, memwb_fwd_data  in  WIDTH  forwarded results.
- exmem_valid  out  1  registered valid.
- exmem_alu_result  out  WIDTH  registered ALU result.
- exmem_zero  out  1  registered (result == 0).
- exmem_store_data  out  WIDTH  registered forwarded rt value (pre alu_src mux).
- exmem_rd  out  5  registered destination.
- exmem_mem_read, exmem_mem_write, exmem_reg_write, exmem_mem_to_reg  out  1 each  registered controls.
- exec_count  out  32  count of valid instructions captured.

## Operation
- Operand A = forward mux(fwd_a) over rs_data; fwd_rt = forward mux(fwd_b) over rt_data; operand B = alu_src ? imm : fwd_rt.
- ALU is combinational: and, or, add (mod 2^WIDTH), sub (A − B mod 2^WIDTH), slt = 1 if A < B signed else 0 (zero-extended to WIDTH). Codes 011/100/101 execute add.
- Register update (rising clk), priority flush > stall > capture:
  - flush: exmem_valid and all four control outputs ← 0; result, store_data, rd ← 0; zero ← 0.
  - stall (no flush): every EX/MEM output holds; exec_count holds.
  - capture: all outputs load new values; if id_valid = 0, controls and exmem_valid are forced 0 (bubble) while data fields still load.
- exec_count increments by 1 only on capture with id_valid = 1; wraps 0xFFFFFFFF → 0.
- No internal state other than EX/MEM register and exec_count; two-state operation (normal/held) is set purely by stall/flush each cycle.

## Timing
- Reset (rst low, asynchronous): every output 0, including exec_count and exmem_zero; release synchronous to next clk edge.
- Latency: inputs at edge N appear on exmem_* after edge N+1 (one cycle).
- Forwarding data must be stable before clk edge; no combinational path from inputs to outputs.
- Reset asserted mid-stall or mid-flush: reset wins immediately; no pending state remains.
- Stall held for K cycles: outputs constant for K edges; the instruction presented on the first un-stalled edge is captured.
- Simultaneous stall and flush: flush behaviour.

## Test plan
- Reset: drive rst low mid-run with nonzero outputs -> all outputs 0 without waiting for clk; exec_count = 0.
- ALU ops: A=0x0000000C, B=0x0000000A, alu_src=0 -> and 0x8, or 0xE, add 0x16, sub 0x2, slt 0; A=0xFFFFFFFF, B=1 slt -> 1; sub A=B=5 -> result 0, exmem_zero 1.
- Forwarding: rs_data=1, exmem_fwd_data=0x100, memwb_fwd_data=0x200, add with imm=4, alu_src=1: fwd_a=10 -> 0x104; fwd_a=01 -> 0x204; fwd_a=11 -> 0x5.
- Store path: alu_src=1, fwd_b=10, exmem_fwd_data=0xDEAD -> exmem_store_data=0xDEAD, result=A+imm.
- Stall/flush: capture reg_write=1, rd=7; assert stall 3 cycles with changing inputs -> outputs unchanged, exec_count unchanged; assert stall+flush -> exmem_valid=0, exmem_reg_write=0, exmem_rd=0.
- Counter: 5 valid captures, 2 bubbles (id_valid=0), 1 flush -> exec_count=5; preload scenario of 0xFFFFFFFF valid captures (or forced) -> next capture wraps to 0.
